sdp_impl: RTL and testbench
===========================

Name: sdp_impl

Overview:
- Pipelined 8-bit datapath computing a control-selected arithmetic function of three operands.
- Sits in the equivalence-check environment as the implementation side. It must match the single-cycle reference model (STAGES=1) delayed by three extra cycles.
- One module serves both roles:
  - STAGES=4: pipelined implementation.
  - STAGES=1: reference behaviour.

Parameters:
- WIDTH, 8, operand and result width in bits.
- STAGES, 4, input-to-output latency in clock cycles. Legal values are 1 (reference) and 4 (pipelined); any other value is illegal.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  asynchronous, active-high reset.
- ctl_1  input  1  operation select, MSB.
- ctl_2  input  1  operation select, LSB.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- c  input  WIDTH  operand C, unsigned.
- out  output  WIDTH  registered result.

Behaviour:
- Function f, all arithmetic modulo 2^WIDTH (truncate to the low WIDTH bits, no saturation, no flags):
  - {ctl_1,ctl_2}=00: a*b + c
  - 01: a*b - c (two's-complement wrap)
  - 10: (a + b) * c
  - 11: (a ^ b) + c
- Latency: out at the cycle after edge n equals f(ctl_1,ctl_2,a,b,c sampled at edge n-STAGES+1).
  - STAGES=1: out <= f(inputs) on every edge.
  - STAGES=4: a new result every cycle, no bubbles, no stall or valid handshake.
- STAGES=4 stage partition:
  - S1 registers ctl, a, b, c.
  - S2 computes the product term (a*b, or a+b carried forward) and registers it with c and ctl.
  - S3 completes the multiply/add/subtract per ctl and registers the WIDTH-bit result.
  - S4 is the output register (out).
  - ctl must travel with its data through every stage; no stage may use a fresh ctl.
- Intermediate product width: at least 2*WIDTH internally; truncate only at the final result.
- Reset, asserted asynchronously:
  - All pipeline registers, including ctl copies and out, clear to 0 immediately.
  - Cleared registers represent f=0 results; out stays 0 for STAGES-1 cycles after reset deasserts unless real data arrives.
- Reset mid-operation: in-flight results are discarded, not completed.
- First valid output after reset release: out becomes f(inputs at the first sampling edge) exactly STAGES-1 edges later.
- Inputs are sampled every edge while reset is low; no input hold requirement.
- Equivalence property, for the same input streams:
  - Take the STAGES=1 instance and add a 3-deep zero-reset delay line on its output.
  - That delayed output must equal the STAGES=4 instance's out on every cycle, including during and after reset.

Test Plan:
- Reset then idle: assert reset, release with all inputs 0 -> out=0 on every cycle.
- Latency check: ctl=00, a=3, b=4, c=5 for one cycle, then zeros -> out=17 exactly on the 4th edge after sampling, 0 before and after.
- All modes, streamed back-to-back with a=3, b=4, c=5:
  - ctl=00 -> 17, 01 -> 7, 10 -> 35, 11 -> 12.
  - Results appear on four consecutive cycles in input order.
- Wrap-around: ctl=00, a=16, b=16, c=1 -> 1. ctl=01, a=0, b=9, c=5 -> 251. ctl=10, a=200, b=100, c=2 -> 88.
- Reset mid-stream: stream four nonzero results, assert reset asynchronously between edges -> out is 0 immediately. After release, only post-reset inputs appear, with 4-cycle latency.
- Equivalence: random ctl/a/b/c for 10k cycles with sporadic reset -> STAGES=4 out equals the STAGES=1 out delayed by 3 zero-reset registers every cycle.

Source files
------------

// File: rtl/sdp_impl.sv
// Control-selected 8-bit arithmetic datapath. STAGES=1 gives the single-cycle
// reference behaviour; STAGES=4 gives the pipeline with the same results three cycles later.
module sdp_impl #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4  // 1 = reference, 4 = pipelined
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctl_1,
  input  logic             ctl_2,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] out
);

  localparam int PW = 2 * WIDTH;

  // First half of f: a*b for the multiply-then-add/sub modes, a+b or a^b carried forward otherwise.
  function automatic logic [PW-1:0] product_term(input logic [1:0] ctl,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
    logic [PW-1:0] xw;
    logic [PW-1:0] yw;
    logic [PW-1:0] t;
    xw = {{WIDTH{1'b0}}, x};
    yw = {{WIDTH{1'b0}}, y};
    case (ctl)
      2'b00, 2'b01: t = xw * yw;
      2'b10:        t = xw + yw;
      default:      t = xw ^ yw;
    endcase
    return t;
  endfunction

  // Second half of f; truncation to WIDTH happens only here.
  function automatic logic [WIDTH-1:0] combine(input logic [1:0] ctl,
                                               input logic [PW-1:0] term,
                                               input logic [WIDTH-1:0] z);
    logic [PW-1:0] zw;
    logic [PW-1:0] r;
    zw = {{WIDTH{1'b0}}, z};
    case (ctl)
      2'b01:   r = term - zw;
      2'b10:   r = term * zw;
      default: r = term + zw;
    endcase
    return r[WIDTH-1:0];
  endfunction

  logic [1:0]       ctl_in;
  logic [WIDTH-1:0] out_q;

  assign ctl_in = {ctl_1, ctl_2};
  assign out    = out_q;

  generate
    if (STAGES == 1) begin : g_ref
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          out_q <= '0;
        end else begin
          out_q <= combine(ctl_in, product_term(ctl_in, a, b), c);
        end
      end
    end else begin : g_pipe
      logic [1:0]       s1_ctl_q;
      logic [WIDTH-1:0] s1_a_q;
      logic [WIDTH-1:0] s1_b_q;
      logic [WIDTH-1:0] s1_c_q;
      logic [1:0]       s2_ctl_q;
      logic [PW-1:0]    s2_term_q;
      logic [WIDTH-1:0] s2_c_q;
      logic [PW-1:0]    s2_term_d;
      logic [WIDTH-1:0] s3_res_q;
      logic [WIDTH-1:0] s3_res_d;

      // Each stage uses only the ctl copy registered alongside its own data.
      assign s2_term_d = product_term(s1_ctl_q, s1_a_q, s1_b_q);
      assign s3_res_d  = combine(s2_ctl_q, s2_term_q, s2_c_q);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s1_ctl_q  <= '0;
          s1_a_q    <= '0;
          s1_b_q    <= '0;
          s1_c_q    <= '0;
          s2_ctl_q  <= '0;
          s2_term_q <= '0;
          s2_c_q    <= '0;
          s3_res_q  <= '0;
          out_q     <= '0;
        end else begin
          s1_ctl_q  <= ctl_in;
          s1_a_q    <= a;
          s1_b_q    <= b;
          s1_c_q    <= c;
          s2_ctl_q  <= s1_ctl_q;
          s2_term_q <= s2_term_d;
          s2_c_q    <= s1_c_q;
          s3_res_q  <= s3_res_d;
          out_q     <= s3_res_q;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sdp_impl.sv
// Directed and randomized checks of the 4-stage datapath against hand values,
// a behavioural model, and the STAGES=1 instance behind a 3-deep delay line.
module tb_sdp_impl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ctl_1 = 1'b0;
  logic       ctl_2 = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [7:0] c = '0;
  logic [7:0] out;
  logic [7:0] ref_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sdp_impl #(.WIDTH(8), .STAGES(4)) dut (
    .clk(clk), .reset(reset), .ctl_1(ctl_1), .ctl_2(ctl_2),
    .a(a), .b(b), .c(c), .out(out)
  );

  sdp_impl #(.WIDTH(8), .STAGES(1)) ref_inst (
    .clk(clk), .reset(reset), .ctl_1(ctl_1), .ctl_2(ctl_2),
    .a(a), .b(b), .c(c), .out(ref_out)
  );

  function automatic logic [7:0] f_model(input logic [1:0] ctl, input int x, input int y, input int z);
    int r;
    case (ctl)
      2'b00:   r = x * y + z;
      2'b01:   r = x * y - z + 65536;
      2'b10:   r = (x + y) * z;
      default: r = (x ^ y) + z;
    endcase
    return 8'(r % 256);
  endfunction

  // Behavioural latency model and reference delay line, both cleared by reset.
  logic [7:0] m1, m2, m3, m4;
  logic [7:0] d1, d2, d3;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m1 <= '0; m2 <= '0; m3 <= '0; m4 <= '0;
      d1 <= '0; d2 <= '0; d3 <= '0;
    end else begin
      m1 <= f_model({ctl_1, ctl_2}, int'(a), int'(b), int'(c));
      m2 <= m1; m3 <= m2; m4 <= m3;
      d1 <= ref_out; d2 <= d1; d3 <= d2;
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // At each falling edge: check out, then drive the inputs for the next rising edge.
  task automatic cyc(input string tag, input logic [1:0] ctl, input logic [7:0] x,
                     input logic [7:0] y, input logic [7:0] z, input logic [7:0] exp);
    @(negedge clk);
    check(tag, out, exp);
    {ctl_1, ctl_2} = ctl;
    a = x; b = y; c = z;
  endtask

  logic [1:0] v_ctl [8];
  logic [7:0] v_a   [8];
  logic [7:0] v_b   [8];
  logic [7:0] v_c   [8];
  logic [7:0] v_exp [8];

  initial begin
    // Mode sweep with 3,4,5 followed by the wrap-around cases.
    v_ctl[0] = 2'b00; v_a[0] = 8'd3;   v_b[0] = 8'd4;   v_c[0] = 8'd5; v_exp[0] = 8'd17;
    v_ctl[1] = 2'b01; v_a[1] = 8'd3;   v_b[1] = 8'd4;   v_c[1] = 8'd5; v_exp[1] = 8'd7;
    v_ctl[2] = 2'b10; v_a[2] = 8'd3;   v_b[2] = 8'd4;   v_c[2] = 8'd5; v_exp[2] = 8'd35;
    v_ctl[3] = 2'b11; v_a[3] = 8'd3;   v_b[3] = 8'd4;   v_c[3] = 8'd5; v_exp[3] = 8'd12;
    v_ctl[4] = 2'b00; v_a[4] = 8'd16;  v_b[4] = 8'd16;  v_c[4] = 8'd1; v_exp[4] = 8'd1;
    v_ctl[5] = 2'b01; v_a[5] = 8'd0;   v_b[5] = 8'd9;   v_c[5] = 8'd5; v_exp[5] = 8'd251;
    v_ctl[6] = 2'b10; v_a[6] = 8'd200; v_b[6] = 8'd100; v_c[6] = 8'd2; v_exp[6] = 8'd88;
    v_ctl[7] = 2'b11; v_a[7] = 8'd255; v_b[7] = 8'd15;  v_c[7] = 8'd9; v_exp[7] = 8'd249;

    // Reset then idle.
    #12;
    check("reset_held", out, 8'd0);
    @(negedge clk);
    check("reset_held2", out, 8'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) cyc("idle", 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);

    // Single-shot latency.
    cyc("lat_pre0", 2'b00, 8'd3, 8'd4, 8'd5, 8'd0);
    cyc("lat_pre1", 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
    cyc("lat_pre2", 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
    cyc("lat_pre3", 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
    cyc("lat_hit",  2'b00, 8'd0, 8'd0, 8'd0, 8'd17);
    cyc("lat_post", 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
    cyc("lat_post2", 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
    cyc("lat_post3", 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);

    // Back-to-back stream; result i appears four calls after its inputs.
    for (int i = 0; i < 12; i++) begin
      if (i < 8) cyc($sformatf("stream%0d", i), v_ctl[i], v_a[i], v_b[i], v_c[i],
                     (i >= 4) ? v_exp[i-4] : 8'd0);
      else       cyc($sformatf("stream%0d", i), 2'b00, 8'd0, 8'd0, 8'd0, v_exp[i-4]);
    end
    cyc("stream_drain", 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);

    // Reset mid-stream: results in flight must vanish.
    for (int i = 0; i < 5; i++)
      cyc($sformatf("mid%0d", i), v_ctl[i], v_a[i], v_b[i], v_c[i],
          (i == 4) ? v_exp[0] : 8'd0);
    #2 reset = 1'b1;
    #1 check("async_clear", out, 8'd0);
    @(negedge clk);
    check("in_reset", out, 8'd0);
    reset = 1'b0;
    {ctl_1, ctl_2} = 2'b00; a = 8'd0; b = 8'd0; c = 8'd0;
    for (int i = 0; i < 4; i++) cyc($sformatf("post_rst%0d", i), 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
    cyc("post_vec", 2'b11, 8'd1, 8'd2, 8'd3, 8'd0);
    for (int i = 0; i < 3; i++) cyc($sformatf("post_wait%0d", i), 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
    cyc("post_hit", 2'b00, 8'd0, 8'd0, 8'd0, 8'd6);
    cyc("post_after", 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);

    // Random equivalence with sporadic asynchronous reset.
    begin
      int hold = 0;
      int mism = 0;
      for (int n = 0; n < 10000; n++) begin
        @(negedge clk);
        checks++;
        assert (out === m4) else begin
          errors++; mism++;
          if (mism <= 10) $error("FAIL rand_model cyc=%0d: observed=%0d expected=%0d", n, out, m4);
        end
        checks++;
        assert (out === d3) else begin
          errors++; mism++;
          if (mism <= 10) $error("FAIL rand_equiv cyc=%0d: observed=%0d expected=%0d", n, out, d3);
        end
        {ctl_1, ctl_2} = 2'($urandom_range(0, 3));
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        c = 8'($urandom_range(0, 255));
        if (hold > 0) begin
          hold--;
          if (hold == 0) reset = 1'b0;
        end else if ($urandom_range(0, 99) == 0) begin
          #2 reset = 1'b1;
          hold = 1 + int'($urandom_range(0, 1));
        end
      end
      reset = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
